// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces raw pushbuttons, then presents
// either the debounced level or a sticky "pressed" latch to the processor IN path.
// The sticky latch is cleared by the IN read strobe, so presses between reads
// are not lost; a second press before a read is flagged as overrun.
module input_conditioner #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic             rd_strobe,
  input  logic             mode,
  output logic [WIDTH-1:0] pushbuttons,
  output logic [WIDTH-1:0] stable,
  output logic             press_pending,
  output logic [WIDTH-1:0] overrun
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  state_t           state [WIDTH];
  logic [CW-1:0]    cnt   [WIDTH];
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] press_evt;
  logic [WIDTH-1:0] latch_q;
  logic [WIDTH-1:0] overrun_q;

  // Multi-stage synchronizer chain per bit; the last stage feeds the FSMs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Per-bit debounce FSM; stable is registered alongside the state so it
  // changes on exactly the edge that enters S_HIGH or S_LOW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state[i] <= S_LOW;
        cnt[i]   <= '0;
      end
      stable_q <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        case (state[i])
          S_LOW: begin
            if (sync[i]) begin
              state[i] <= S_RISE;
              cnt[i]   <= CNT_ONE;
            end
          end
          S_RISE: begin
            if (!sync[i]) begin
              state[i] <= S_LOW;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              state[i]    <= S_HIGH;
              cnt[i]      <= '0;
              stable_q[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          S_HIGH: begin
            if (!sync[i]) begin
              state[i] <= S_FALL;
              cnt[i]   <= CNT_ONE;
            end
          end
          S_FALL: begin
            if (sync[i]) begin
              state[i] <= S_HIGH;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              state[i]    <= S_LOW;
              cnt[i]      <= '0;
              stable_q[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            state[i]    <= S_LOW;
            cnt[i]      <= '0;
            stable_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Press event is the S_RISE -> S_HIGH transition condition, so the latch
  // sets on the same edge that stable rises.
  always_comb begin
    press_evt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      press_evt[i] = (state[i] == S_RISE) && sync[i] && (cnt[i] == CNT_MAX);
    end
  end

  // Sticky latch and overrun flags; a press in the read cycle is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q   <= '0;
      overrun_q <= '0;
    end else begin
      latch_q   <= press_evt | (rd_strobe ? '0 : latch_q);
      overrun_q <= rd_strobe ? '0 : (overrun_q | (press_evt & latch_q));
    end
  end

  assign stable        = stable_q;
  assign overrun       = overrun_q;
  assign press_pending = |latch_q;
  assign pushbuttons   = mode ? latch_q : stable_q;

endmodule
